modadd_sched: RTL and testbench

- Two-requester scheduler that time-shares one modular adder instance (modadd, FF_IN=FF_ADD=FF_OUT=1, 3-cycle latency) between independent clients.
- Owns the modulus-high register qH and sequences its reconfiguration: it drains in-flight operations before loading a new modulus, so no result mixes two moduli.
- Sits between NTT/butterfly datapath clients and the shared modadd datapath.

---
 rtl/modadd_sched_if.sv | 56 +++++
 rtl/modadd_sched.sv | 152 +++++++++++++++
 tb/tb_modadd_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modadd_sched_if.sv
// +--------------------------------------------------------------------+
// | modadd_sched_if : client/config bus of the modadd scheduler        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface modadd_sched_if #(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 47,
    parameter int TAGW  = 4
);
    logic             cfg_we;
    logic [LOGQH-1:0] cfg_qh;
    logic             cfg_ack;
    logic             busy;

    logic             req0_valid;
    logic             req0_ready;
    logic [LOGQ-1:0]  req0_a;
    logic [LOGQ-1:0]  req0_b;
    logic [TAGW-1:0]  req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [LOGQ-1:0]  req1_a;
    logic [LOGQ-1:0]  req1_b;
    logic [TAGW-1:0]  req1_tag;

    logic             rsp0_valid;
    logic [LOGQ-1:0]  rsp0_c;
    logic [TAGW-1:0]  rsp0_tag;

    logic             rsp1_valid;
    logic [LOGQ-1:0]  rsp1_c;
    logic [TAGW-1:0]  rsp1_tag;

    modport master (
        output cfg_we, cfg_qh,
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        input  cfg_ack, busy, req0_ready, req1_ready,
        input  rsp0_valid, rsp0_c, rsp0_tag,
        input  rsp1_valid, rsp1_c, rsp1_tag
    );

    modport slave (
        input  cfg_we, cfg_qh,
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        output cfg_ack, busy, req0_ready, req1_ready,
        output rsp0_valid, rsp0_c, rsp0_tag,
        output rsp1_valid, rsp1_c, rsp1_tag
    );
endinterface

`default_nettype wire

// File: rtl/modadd_sched.sv
// +--------------------------------------------------------------------+
// | modadd_sched : two-client round-robin front end for a 3-stage      |
// | modular adder, with drain-before-load modulus reconfiguration      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module modadd_sched #(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 47,
    parameter int TAGW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    modadd_sched_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state;
    logic [LOGQH-1:0]  qh;
    logic              rr_ptr;
    logic [1:0]        count;
    logic              cfg_ack;

    logic [2:0]        pipe_v;
    logic [2:0]        pipe_id;
    logic [TAGW-1:0]   pipe_tag [3];

    logic [LOGQ-1:0]   q;
    logic [LOGQ-1:0]   stg1_a;
    logic [LOGQ-1:0]   stg1_b;
    logic [LOGQ-1:0]   stg1_q;
    logic [LOGQ-1:0]   stg2_r;
    logic [LOGQ-1:0]   stg2_rq;
    logic              stg2_ge;
    logic [LOGQ-1:0]   stg3_c;

    logic [LOGQ:0]     sum;
    logic              can_grant;
    logic              gnt0;
    logic              gnt1;
    logic              grant;
    logic              retire;

    generate
        if (LOGQ > LOGQH) begin : g_q_split
            assign q = (LOGQ'(qh) << (LOGQ - LOGQH)) | LOGQ'(1);
        end else begin : g_q_full
            assign q = LOGQ'(qh);
        end
    endgenerate

    // Grants are withheld outside RUN and on the very cycle a reload is requested.
    always_comb begin
        can_grant = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        can_grant = rst_n && (state == RUN) && !bus.cfg_we;
        gnt0      = can_grant && bus.req0_valid && (!bus.req1_valid || !rr_ptr);
        gnt1      = can_grant && bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
    end

    assign grant  = gnt0 || gnt1;
    assign retire = pipe_v[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            qh      <= '0;
            cfg_ack <= 1'b0;
            rr_ptr  <= 1'b0;
            count   <= 2'd0;
            pipe_v  <= 3'b000;
            pipe_id <= 3'b000;
        end else begin
            cfg_ack <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.cfg_we) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == 2'd0) begin
                        qh      <= bus.cfg_qh;
                        cfg_ack <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            // Priority passes to the requester that did not just win.
            if (grant) begin
                rr_ptr <= gnt0;
            end

            case ({grant, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            pipe_v  <= {pipe_v[1:0], grant};
            pipe_id <= {pipe_id[1:0], gnt1};
        end
    end

    assign sum = {1'b0, stg1_a} + {1'b0, stg1_b};

    // Datapath carries no control meaning on its own, so it needs no reset.
    always_ff @(posedge clk) begin
        stg1_a      <= gnt1 ? bus.req1_a   : bus.req0_a;
        stg1_b      <= gnt1 ? bus.req1_b   : bus.req0_b;
        pipe_tag[0] <= gnt1 ? bus.req1_tag : bus.req0_tag;
        stg1_q      <= q;

        // R - q is non-negative exactly when R >= q.
        stg2_r      <= sum[LOGQ-1:0];
        stg2_rq     <= sum[LOGQ-1:0] - stg1_q;
        stg2_ge     <= (sum >= {1'b0, stg1_q});
        pipe_tag[1] <= pipe_tag[0];

        stg3_c      <= stg2_ge ? stg2_rq : stg2_r;
        pipe_tag[2] <= pipe_tag[1];
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.cfg_ack    = cfg_ack;
    assign bus.busy       = (count != 2'd0) || (state == DRAIN);

    assign bus.rsp0_valid = pipe_v[2] && !pipe_id[2];
    assign bus.rsp0_c     = stg3_c;
    assign bus.rsp0_tag   = pipe_tag[2];
    assign bus.rsp1_valid = pipe_v[2] &&  pipe_id[2];
    assign bus.rsp1_c     = stg3_c;
    assign bus.rsp1_tag   = pipe_tag[2];

endmodule

`default_nettype wire

// File: tb/tb_modadd_sched.sv
// +--------------------------------------------------------------------+
// | tb_modadd_sched : directed self-checking bench for modadd_sched    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_modadd_sched;

    localparam int LOGQ  = 64;
    localparam int LOGQH = 47;
    localparam int TAGW  = 4;

    typedef struct {
        bit          req;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  tag;
        logic [63:0] c;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vec_t        vecs [5];
    logic [63:0] dra  [4];
    logic [63:0] drb  [4];
    logic [63:0] drc  [4];

    modadd_sched_if #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) bus ();

    modadd_sched #(.LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.cfg_we     = 1'b0;
        bus.cfg_qh     = '0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_tag   = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_tag   = '0;
    endtask

    task automatic do_cfg(input logic [LOGQH-1:0] val, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_qh = val;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.cfg_ack) lat = i;
        end
        check("cfg_ack_latency", 64'(lat), 64'(exp_lat));
        bus.cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_ack_pulse", 64'(bus.cfg_ack), 64'd0);
        check("cfg_busy_after", 64'(bus.busy), 64'd0);
        check("cfg_qh_loaded", 64'(dut.qh), 64'(val));
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        if (v.req) begin
            bus.req1_valid = 1'b1; bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_tag = v.tag;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_tag = v.tag;
        end
        #1;
        check("vec_ready", 64'(v.req ? bus.req1_ready : bus.req0_ready), 64'd1);
        check("vec_other_ready", 64'(v.req ? bus.req0_ready : bus.req1_ready), 64'd0);
        @(posedge clk);
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                seen = 1'b1;
                check("vec_latency", 64'(i), 64'd3);
                check("vec_rsp_sel", 64'({bus.rsp1_valid, bus.rsp0_valid}), v.req ? 64'd2 : 64'd1);
                check("vec_c", v.req ? bus.rsp1_c : bus.rsp0_c, v.c);
                check("vec_tag", 64'(v.req ? bus.rsp1_tag : bus.rsp0_tag), 64'(v.tag));
            end
        end
        if (!seen) check("vec_rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int  k0;
        int  k1;
        int  idx;
        bit  exp_rsp;
        bit  exp_r;
        int  exp_k;

        checks   = 0;
        failures = 0;

        // q = 0x20001 once qH = 1
        vecs[0] = '{req: 1'b0, a: 64'h5,     b: 64'h7,     tag: 4'h3, c: 64'hC};
        vecs[1] = '{req: 1'b1, a: 64'h20000, b: 64'h2,     tag: 4'h5, c: 64'h1};
        vecs[2] = '{req: 1'b1, a: 64'h20000, b: 64'h1,     tag: 4'h6, c: 64'h0};
        vecs[3] = '{req: 1'b0, a: 64'h10000, b: 64'h10000, tag: 4'h9, c: 64'h20000};
        vecs[4] = '{req: 1'b1, a: 64'h20000, b: 64'h20000, tag: 4'hA, c: 64'h1FFFF};

        dra = '{64'h20000, 64'h1FFFF, 64'h100, 64'h40002};
        drb = '{64'h10,    64'h2,     64'h200, 64'h0};
        drc = '{64'hF,     64'h0,     64'h300, 64'h1};

        idle_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ack", 64'(bus.cfg_ack), 64'd0);
        check("rst_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        check("rst_qh", 64'(dut.qh), 64'd0);
        check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;

        do_cfg(47'd1, 2);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Both requesters valid for 8 grants: must alternate 0,1,0,1...
        k0 = 0;
        k1 = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            exp_rsp = (j >= 3) && (j < 11);
            check("rr_rsp_valid", 64'(bus.rsp0_valid || bus.rsp1_valid), 64'(exp_rsp));
            if (exp_rsp) begin
                exp_r = ((j - 3) % 2) == 1;
                exp_k = (j - 3) / 2;
                check("rr_rsp_sel", 64'({bus.rsp1_valid, bus.rsp0_valid}), exp_r ? 64'd2 : 64'd1);
                check("rr_rsp_c", exp_r ? bus.rsp1_c : bus.rsp0_c, 64'(16 * int'(exp_r) + exp_k + 1 + 100));
                check("rr_rsp_tag", 64'(exp_r ? bus.rsp1_tag : bus.rsp0_tag), 64'(8 * int'(exp_r) + exp_k));
            end
            if (j < 8) begin
                bus.req0_valid = 1'b1;
                bus.req0_a     = 64'(k0 + 1);
                bus.req0_b     = 64'd100;
                bus.req0_tag   = 4'(k0);
                bus.req1_valid = 1'b1;
                bus.req1_a     = 64'(16 + k1 + 1);
                bus.req1_b     = 64'd100;
                bus.req1_tag   = 4'(8 + k1);
                #1;
                check("rr_grant", 64'({bus.req1_ready, bus.req0_ready}), (j % 2 == 0) ? 64'd1 : 64'd2);
                if (bus.req0_ready) k0++;
                if (bus.req1_ready) k1++;
            end else begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end

        // Three streamed ops, then reload qH=2 while they drain.
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            exp_rsp = ((j >= 3) && (j <= 5)) || (j == 11);
            check("drain_rsp_v", 64'({bus.rsp1_valid, bus.rsp0_valid}), exp_rsp ? 64'd1 : 64'd0);
            if (exp_rsp) begin
                idx = (j == 11) ? 3 : j - 3;
                check("drain_rsp_c", bus.rsp0_c, drc[idx]);
                check("drain_rsp_tag", 64'(bus.rsp0_tag), 64'(idx + 1));
            end
            check("drain_ack", 64'(bus.cfg_ack), 64'(j == 7));
            check("drain_busy", 64'(bus.busy), 64'(((j >= 1) && (j <= 6)) || ((j >= 9) && (j <= 11))));
            if (j >= 3 && j <= 6) check("drain_qh_hold", 64'(dut.qh), 64'd1);
            if (j == 7) check("drain_qh_new", 64'(dut.qh), 64'd2);
            if (j <= 8) begin
                idx = (j < 3) ? j : 3;
                bus.req0_valid = 1'b1;
                bus.req0_a     = dra[idx];
                bus.req0_b     = drb[idx];
                bus.req0_tag   = 4'(idx + 1);
            end else begin
                bus.req0_valid = 1'b0;
            end
            if (j == 3) begin
                bus.cfg_we = 1'b1;
                bus.cfg_qh = 47'd2;
            end
            if (j == 8) bus.cfg_we = 1'b0;
            #1;
            check("drain_ready", 64'(bus.req0_ready), 64'((j < 3) || (j == 8)));
        end

        // Reset one cycle after an accept drops the op in flight.
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j >= 1) check("rstdrop_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
            if (j == 1) check("rstdrop_busy_pre", 64'(bus.busy), 64'd1);
            if (j >= 2) begin
                check("rstdrop_busy", 64'(bus.busy), 64'd0);
                check("rstdrop_qh", 64'(dut.qh), 64'd0);
                check("rstdrop_rr", 64'(dut.rr_ptr), 64'd0);
            end
            if (j == 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_a     = 64'd1;
                bus.req0_b     = 64'd1;
                bus.req0_tag   = 4'h7;
                #1;
                check("rstdrop_ready", 64'(bus.req0_ready), 64'd1);
            end
            if (j == 1) begin
                bus.req0_valid = 1'b0;
                rst_n = 1'b0;
            end
            if (j == 2) rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
